ram_burst_master: RTL
=====================

RAM_BURST_MASTER -- requirements
Module: ram_burst_master

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port start  input  1  command strobe, sampled only when busy=0.
REQ-004 SHALL have port op  input  1  command type, 0=read burst, 1=write burst.
REQ-005 SHALL have port base  input  4  first RAM word address of the burst.
REQ-006 SHALL have port len  input  4  beats minus one (0..15 means 1..16 beats).
REQ-007 SHALL have port wdata  input  4  write beat data.
REQ-008 SHALL have port wvalid  input  1  write beat offered.
REQ-009 SHALL have port wready  output  1  write beat accepted when wvalid=1 and wready=1 at a clock edge.
REQ-010 SHALL have port rdata  output  4  read beat data, valid only while rvalid=1.
REQ-011 SHALL have port rvalid  output  1  one-cycle pulse per read beat; no backpressure.
REQ-012 SHALL have port busy  output  1  high from the cycle after start acceptance until burst completion.
REQ-013 SHALL have port done  output  1  one-cycle pulse on burst completion.
REQ-014 SHALL have port ram_addr  output  4  address to the 16x4 synchronous RAM.
REQ-015 SHALL have port ram_read  output  1  RAM read enable; RAM returns data on its dataout one cycle later.
REQ-016 SHALL have port ram_write  output  1  RAM write enable.
REQ-017 SHALL have port ram_datain  output  4  RAM write data.
REQ-018 SHALL have port ram_dataout  input  4  registered RAM read data.

Function
REQ-019 SHALL implement states IDLE, WR, RD, RD_DRAIN; every output SHALL be driven from a register.
REQ-020 In IDLE, start=1 at an edge SHALL latch op, base and len, load the address counter with base, load the beat counter with len, and enter WR (op=1) or RD (op=0).
REQ-021 start SHALL be ignored while busy=1; wvalid SHALL be ignored outside WR.
REQ-022 The address SHALL increment by 1 modulo 16 per beat (15 wraps to 0).
REQ-023 WR: wready=1; each accepted beat SHALL produce, in the next cycle, ram_write=1, ram_addr=current address, ram_datain=accepted wdata; with wvalid held high, one beat per cycle.
REQ-024 WR: wready SHALL drop in the cycle after the last beat is accepted; done=1 and busy=0 SHALL coincide with the last ram_write cycle being followed by return to IDLE (done in the cycle after the last ram_write).
REQ-025 RD: ram_read=1 for len+1 consecutive cycles at consecutive addresses, then RD_DRAIN.
REQ-026 A read issued in cycle k SHALL be captured from ram_dataout at the end of cycle k+1 and presented as rdata with rvalid=1 in cycle k+2.
REQ-027 RD_DRAIN SHALL last until the last beat's rvalid cycle, which SHALL also be the first IDLE cycle, with done=1 and busy=0.
REQ-028 In IDLE, ram_read, ram_write, wready, rvalid and done SHALL be 0; a start SHALL be accepted in the same cycle in which done=1.
REQ-029 rvalid pulses SHALL number exactly len+1 per read burst, in address order.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE and all outputs to 0 (rdata=0, ram_addr=0, ram_datain=0), regardless of clk.
REQ-031 rst asserted mid-burst SHALL abandon the burst with no done pulse; RAM words already written SHALL remain written.
REQ-032 rst=1 coincident with start SHALL win; the command is discarded.

Verification
REQ-033 Write base=3 len=3 data 1,2,3,4 back-to-back -> ram_write on 4 consecutive cycles at addresses 3,4,5,6; done 1 cycle after the last write.
REQ-034 Read base=3 len=3 after REQ-033 -> first rvalid 3 cycles after the start edge; rdata 1,2,3,4 on consecutive cycles; done with the 4th rvalid.
REQ-035 Write base=14 len=3 data A,B,C,D, then read back -> addresses 14,15,0,1; rdata A,B,C,D.
REQ-036 Write with wvalid gapped (1 on, 2 off) len=1 -> exactly 2 ram_write pulses, one per accepted beat; busy held across gaps.
REQ-037 start pulsed while busy during a len=15 read -> ignored; exactly 16 rvalid pulses; then a start in the done cycle is accepted.
REQ-038 rst asserted during beat 2 of a len=7 read -> all outputs 0 within the same cycle; no further rvalid and no done.

Source files
------------

// File: rtl/ram_burst_master_if.sv
// Command, write-beat, read-beat and RAM-side signals of the burst master.
interface ram_burst_master_if;
   logic       start;
   logic       op;
   logic [3:0] base;
   logic [3:0] len;
   logic [3:0] wdata;
   logic       wvalid;
   logic       wready;
   logic [3:0] rdata;
   logic       rvalid;
   logic       busy;
   logic       done;
   logic [3:0] ram_addr;
   logic       ram_read;
   logic       ram_write;
   logic [3:0] ram_datain;
   logic [3:0] ram_dataout;

   modport master (
      input  start, op, base, len, wdata, wvalid, ram_dataout,
      output wready, rdata, rvalid, busy, done,
      output ram_addr, ram_read, ram_write, ram_datain
   );

   modport slave (
      output start, op, base, len, wdata, wvalid, ram_dataout,
      input  wready, rdata, rvalid, busy, done,
      input  ram_addr, ram_read, ram_write, ram_datain
   );
endinterface

// File: rtl/ram_burst_master.sv
// Burst read/write master for a 16x4 synchronous RAM.
// All outputs are registered; reads return two cycles after issue.
module ram_burst_master (
   input  logic                clk,
   input  logic                rst,
   ram_burst_master_if.master  bus
);
   typedef enum logic [1:0] {IDLE, WR, RD, RD_DRAIN} state_e;

   state_e     state_q, state_d;
   logic [3:0] addr_q, addr_d;
   logic [3:0] cnt_q, cnt_d;
   logic       wready_q, wready_d;
   logic       ram_write_q, ram_write_d;
   logic       ram_read_q, ram_read_d;
   logic [3:0] ram_addr_q, ram_addr_d;
   logic [3:0] datain_q, datain_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       rvalid_q, rvalid_d;
   logic [3:0] rdata_q, rdata_d;
   logic       rd_pend_q, rd_pend_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (bus.start) state_d = bus.op ? WR : RD;
         WR:       if (!wready_q) state_d = IDLE;
         RD:       if (cnt_q == 4'd0) state_d = RD_DRAIN;
         RD_DRAIN: state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      wready_d    = 1'b0;
      ram_write_d = 1'b0;
      ram_read_d  = 1'b0;
      ram_addr_d  = ram_addr_q;
      datain_d    = datain_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      // RAM data lags ram_read by one cycle; capture it then
      rd_pend_d   = ram_read_q;
      rvalid_d    = rd_pend_q;
      rdata_d     = rd_pend_q ? bus.ram_dataout : rdata_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               addr_d = bus.base;
               cnt_d  = bus.len;
               busy_d = 1'b1;
               if (bus.op) begin
                  wready_d = 1'b1;
               end else begin
                  ram_read_d = 1'b1;
                  ram_addr_d = bus.base;
                  addr_d     = bus.base + 4'd1;
               end
            end
         end
         WR: begin
            if (wready_q) begin
               wready_d = 1'b1;
               if (bus.wvalid) begin
                  ram_write_d = 1'b1;
                  ram_addr_d  = addr_q;
                  datain_d    = bus.wdata;
                  addr_d      = addr_q + 4'd1;
                  cnt_d       = cnt_q - 4'd1;
                  if (cnt_q == 4'd0) wready_d = 1'b0;
               end
            end else begin
               done_d = 1'b1;
               busy_d = 1'b0;
            end
         end
         RD: begin
            if (cnt_q != 4'd0) begin
               ram_read_d = 1'b1;
               ram_addr_d = addr_q;
               addr_d     = addr_q + 4'd1;
               cnt_d      = cnt_q - 4'd1;
            end
         end
         RD_DRAIN: begin
            done_d = 1'b1;
            busy_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q      <= 4'd0;
         cnt_q       <= 4'd0;
         wready_q    <= 1'b0;
         ram_write_q <= 1'b0;
         ram_read_q  <= 1'b0;
         ram_addr_q  <= 4'd0;
         datain_q    <= 4'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= 4'd0;
         rd_pend_q   <= 1'b0;
      end else begin
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         wready_q    <= wready_d;
         ram_write_q <= ram_write_d;
         ram_read_q  <= ram_read_d;
         ram_addr_q  <= ram_addr_d;
         datain_q    <= datain_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         rd_pend_q   <= rd_pend_d;
      end
   end

   assign bus.wready     = wready_q;
   assign bus.ram_write  = ram_write_q;
   assign bus.ram_read   = ram_read_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_datain = datain_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.rvalid     = rvalid_q;
   assign bus.rdata      = rdata_q;
endmodule
